tf_ctrl: RTL and testbench

TF_CTRL -- requirements
Module: tf_ctrl

---
 rtl/tf_pkg.sv | 17 +
 rtl/tf_ctrl_if.sv | 36 +++
 rtl/tf_ctrl.sv | 110 +++++++++++
 tb/tb_tf_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/tf_pkg.sv
// Shared definitions for the twiddle-factor controller: state encoding and default sizing.
package tf_pkg;

    localparam int D_WIDTH_DEF  = 32;
    localparam int IT_DEPTH_DEF = 3;
    localparam int MUL_LAT_DEF  = 3;

    typedef enum logic [2:0] {
        IDLE,
        LD_CONST,
        LD_BASE,
        READY,
        RD,
        WR
    } tf_state_e;

endpackage

// File: rtl/tf_ctrl_if.sv
// Bundle of source handshake, update request and twiddle-generator control signals.
interface tf_ctrl_if
    import tf_pkg::*;
#(
    parameter int D_WIDTH = D_WIDTH_DEF
);

    logic               start;
    logic               src_valid;
    logic               upd_req;
    logic [D_WIDTH-1:0] upd_depth;

    logic               src_req;
    logic               src_kind;
    logic               TF_init_const;
    logic               TF_init_base;
    logic               TF_ren;
    logic               TF_wen;
    logic [D_WIDTH-1:0] it_depth_cnt;
    logic               ready;
    logic               upd_ack;
    logic               upd_err;

    modport master (
        output start, src_valid, upd_req, upd_depth,
        input  src_req, src_kind, TF_init_const, TF_init_base, TF_ren, TF_wen,
        input  it_depth_cnt, ready, upd_ack, upd_err
    );

    modport slave (
        input  start, src_valid, upd_req, upd_depth,
        output src_req, src_kind, TF_init_const, TF_init_base, TF_ren, TF_wen,
        output it_depth_cnt, ready, upd_ack, upd_err
    );

endinterface

// File: rtl/tf_ctrl.sv
// Twiddle generator sequencer: loads constants and per-depth bases, then services
// single-multiply base updates with a fixed multiplier latency.
module tf_ctrl
    import tf_pkg::*;
#(
    parameter int D_WIDTH  = D_WIDTH_DEF,
    parameter int IT_DEPTH = IT_DEPTH_DEF,
    parameter int MUL_LAT  = MUL_LAT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    tf_ctrl_if.slave   bus
);

    localparam int                 LAT_W      = $clog2(MUL_LAT + 1);
    localparam logic [D_WIDTH-1:0] DEPTH_LAST = D_WIDTH'(IT_DEPTH - 1);
    localparam logic [D_WIDTH-1:0] DEPTH_NUM  = D_WIDTH'(IT_DEPTH);
    localparam logic [LAT_W-1:0]   LAT_LOAD   = LAT_W'(MUL_LAT);

    tf_state_e          state, state_nxt;
    logic [D_WIDTH-1:0] depth_cnt, depth_nxt;
    logic [LAT_W-1:0]   lat_cnt, lat_nxt;
    logic               err_q, err_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            depth_cnt <= '0;
            lat_cnt   <= '0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            depth_cnt <= depth_nxt;
            lat_cnt   <= lat_nxt;
            err_q     <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        depth_nxt = depth_cnt;
        lat_nxt   = lat_cnt;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = LD_CONST;
                    depth_nxt = '0;
                end
            end
            LD_CONST: begin
                if (bus.src_valid) begin
                    state_nxt = LD_BASE;
                    depth_nxt = '0;
                end
            end
            LD_BASE: begin
                if (bus.src_valid) begin
                    if (depth_cnt == DEPTH_LAST) begin
                        state_nxt = READY;
                        depth_nxt = '0;
                    end else begin
                        depth_nxt = depth_cnt + D_WIDTH'(1);
                    end
                end
            end
            READY: begin
                // A reload request takes priority over a coincident update.
                if (bus.start) begin
                    state_nxt = LD_CONST;
                    depth_nxt = '0;
                end else if (bus.upd_req) begin
                    if (bus.upd_depth < DEPTH_NUM) begin
                        state_nxt = RD;
                        depth_nxt = bus.upd_depth;
                        lat_nxt   = LAT_LOAD;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            RD: begin
                lat_nxt = lat_cnt - LAT_W'(1);
                if (lat_cnt == LAT_W'(1)) state_nxt = WR;
            end
            WR: begin
                state_nxt = READY;
                lat_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                depth_nxt = '0;
                lat_nxt   = '0;
            end
        endcase
    end

    // Strobes decode from registered state; load strobes additionally qualify on src_valid.
    assign bus.src_req       = (state == LD_CONST) || (state == LD_BASE);
    assign bus.src_kind      = (state == LD_BASE);
    assign bus.TF_init_const = (state == LD_CONST) && bus.src_valid;
    assign bus.TF_init_base  = (state == LD_BASE) && bus.src_valid;
    assign bus.TF_ren        = (state == RD);
    assign bus.TF_wen        = (state == WR);
    assign bus.it_depth_cnt  = depth_cnt;
    assign bus.ready         = (state == READY);
    assign bus.upd_ack       = (state == WR);
    assign bus.upd_err       = err_q;

endmodule

// File: tb/tb_tf_ctrl.sv
// Directed bench for tf_ctrl with IT_DEPTH=3, MUL_LAT=3.
module tb_tf_ctrl;

    localparam int D_WIDTH = 32;

    // {src_req, src_kind, init_const, init_base, ren, wen, ready, upd_ack, upd_err}
    localparam logic [8:0] F_IDLE    = 9'b000000000;
    localparam logic [8:0] F_CONST   = 9'b101000000;
    localparam logic [8:0] F_CONST_W = 9'b100000000;
    localparam logic [8:0] F_BASE    = 9'b110100000;
    localparam logic [8:0] F_BASE_W  = 9'b110000000;
    localparam logic [8:0] F_RDY     = 9'b000000100;
    localparam logic [8:0] F_ERR     = 9'b000000101;
    localparam logic [8:0] F_REN     = 9'b000010000;
    localparam logic [8:0] F_WEN     = 9'b000001010;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int   dep [5] = '{0, 1, 1, 1, 2};

    tf_ctrl_if #(.D_WIDTH(D_WIDTH)) bus ();

    tf_ctrl #(.D_WIDTH(D_WIDTH), .IT_DEPTH(3), .MUL_LAT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] flags();
        return {bus.src_req, bus.src_kind, bus.TF_init_const, bus.TF_init_base,
                bus.TF_ren, bus.TF_wen, bus.ready, bus.upd_ack, bus.upd_err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic look(input string tag, input logic [8:0] ef, input int ed);
        chk({tag, "_flags"}, 32'(flags()), 32'(ef));
        chk({tag, "_depth"}, bus.it_depth_cnt, 32'(ed));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.src_valid = 1'b0;
        bus.upd_req   = 1'b0;
        bus.upd_depth = '0;
        repeat (2) @(posedge clk);
        #1;
        look("in_reset", F_IDLE, 0);
        rst = 1'b0;
        #1;
        look("idle", F_IDLE, 0);

        // IDLE ignores everything except start
        bus.src_valid = 1'b1; bus.upd_req = 1'b1; bus.upd_depth = 1;
        #1;
        look("idle_ign", F_IDLE, 0);
        tick();
        look("idle_ign2", F_IDLE, 0);

        // full load with src_valid held high
        bus.upd_req = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        #1;
        look("ld_const", F_CONST, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            look("ld_base", F_BASE, i);
        end
        tick();
        look("ready_after_load", F_RDY, 0);

        // reload with gappy src_valid during LD_BASE
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        #1;
        look("reload_const", F_CONST, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            bus.src_valid = pat[i];
            #1;
            look("gap_base", pat[i] ? F_BASE : F_BASE_W, dep[i]);
            tick();
        end
        bus.src_valid = 1'b0;
        #1;
        look("gap_ready", F_RDY, 0);

        // update of depth 2: three read cycles, one write-back
        bus.upd_req = 1'b1; bus.upd_depth = 2;
        #1;
        look("upd_accept", F_RDY, 0);
        tick();
        bus.upd_req = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            look("upd_rd", F_REN, 2);
            tick();
        end
        look("upd_wr", F_WEN, 2);
        tick();
        chk("upd_back_ready", 32'(flags()), 32'(F_RDY));

        // out-of-range depths: 5 and exactly IT_DEPTH
        for (int d = 3; d <= 5; d += 2) begin
            bus.upd_req = 1'b1; bus.upd_depth = d;
            #1;
            chk("err_req_cycle", 32'(flags()), 32'(F_RDY));
            tick();
            bus.upd_req = 1'b0;
            #1;
            chk("err_pulse", 32'(flags()), 32'(F_ERR));
            tick();
            chk("err_cleared", 32'(flags()), 32'(F_RDY));
        end

        // start and upd_req together: start wins
        bus.start = 1'b1; bus.upd_req = 1'b1; bus.upd_depth = 1;
        tick();
        bus.start = 1'b0; bus.upd_req = 1'b0;
        #1;
        look("sw_const_wait", F_CONST_W, 0);
        tick();
        look("sw_const_wait2", F_CONST_W, 0);
        bus.src_valid = 1'b1;
        #1;
        look("sw_const", F_CONST, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            look("sw_base", F_BASE, i);
        end
        tick();
        bus.src_valid = 1'b0;
        #1;
        look("sw_ready", F_RDY, 0);

        // reset during the second read cycle
        bus.upd_req = 1'b1; bus.upd_depth = 1;
        tick();
        bus.upd_req = 1'b0;
        #1;
        look("pre_rst_rd1", F_REN, 1);
        tick();
        look("pre_rst_rd2", F_REN, 1);
        rst = 1'b1;
        #1;
        look("mid_rst", F_IDLE, 0);
        tick();
        rst = 1'b0;
        bus.upd_req = 1'b1; bus.upd_depth = 1;
        tick();
        bus.upd_req = 1'b0;
        #1;
        look("post_rst_ign", F_IDLE, 0);
        tick();
        look("post_rst_ign2", F_IDLE, 0);

        // reload, then an update of depth 0 works again
        bus.start = 1'b1; bus.src_valid = 1'b1;
        tick();
        bus.start = 1'b0;
        #1;
        look("rl_const", F_CONST, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            look("rl_base", F_BASE, i);
        end
        tick();
        bus.src_valid = 1'b0;
        #1;
        look("rl_ready", F_RDY, 0);
        bus.upd_req = 1'b1; bus.upd_depth = 0;
        tick();
        bus.upd_req = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            look("rl_rd", F_REN, 0);
            tick();
        end
        look("rl_wr", F_WEN, 0);
        tick();
        chk("rl_back_ready", 32'(flags()), 32'(F_RDY));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
